// File: rtl/l2_write_buffer.sv
// Victim-line write buffer between the L1 controller and L2: lines are filled one
// 32-bit beat per cycle, queued in a DEPTH-entry ring and drained as address/data beats.
module l2_write_buffer #(
    parameter int DEPTH = 4,
    parameter int WORDS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_l2,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_data,
    output logic        wb_ready,
    output logic        wb_full,
    input  logic [31:0] chk_addr,
    output logic        chk_hit,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    input  logic        mem_ack,
    output logic        empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = $clog2(WORDS);
    localparam int LB = WW + 2;
    localparam int TW = 32 - LB;
    localparam logic [WW-1:0] LAST_BEAT = WW'(WORDS - 1);
    localparam logic [WW-1:0] BEAT_ONE  = 1;
    localparam logic [PW-1:0] PTR_ONE   = 1;
    localparam logic [PW:0]   CNT_ONE   = 1;
    localparam logic [PW:0]   FULL_CNT  = DEPTH[PW:0];

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [PW:0]       count_q, count_d;
    logic [WW-1:0]     fill_cnt_q, fill_cnt_d, drain_cnt_q, drain_cnt_d;
    logic              wb_ready_q;
    logic [TW-1:0]     tag_q [DEPTH];
    logic [31:0]       data_mem [DEPTH*WORDS];
    logic [31:0]       rd_data_q;
    logic              accept, fill_last, drain_beat, drain_last;
    logic [DEPTH-1:0]  hit_vec;
    logic              unused_low_bits;

    assign accept     = write_l2 && !wb_full;
    assign fill_last  = accept && (fill_cnt_q == LAST_BEAT);
    assign drain_beat = (state_q == SEND) && mem_ack;
    assign drain_last = drain_beat && (drain_cnt_q == LAST_BEAT);

    always_comb begin
        wp_d        = wp_q;
        rp_d        = rp_q;
        fill_cnt_d  = fill_cnt_q;
        drain_cnt_d = drain_cnt_q;
        count_d     = count_q;
        state_d     = state_q;
        if (accept) begin
            fill_cnt_d = fill_cnt_q + BEAT_ONE;
            if (fill_last) wp_d = wp_q + PTR_ONE;
        end
        if (drain_beat) begin
            drain_cnt_d = drain_cnt_q + BEAT_ONE;
            if (drain_last) rp_d = rp_q + PTR_ONE;
        end
        if (fill_last && !drain_last) begin
            count_d = count_q + CNT_ONE;
        end else if (!fill_last && drain_last) begin
            count_d = count_q - CNT_ONE;
        end
        case (state_q)
            IDLE:    if (count_q != '0) state_d = SEND;
            SEND:    if (drain_last && (count_d == '0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            fill_cnt_q  <= '0;
            drain_cnt_q <= '0;
            wb_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            fill_cnt_q  <= fill_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            wb_ready_q  <= fill_last;
        end
    end

    // The read index follows the next drain position, so the registered word is
    // already the one to present once the pointers have moved.
    always_ff @(posedge clk) begin
        if (accept) data_mem[{wp_q, fill_cnt_q}] <= wb_data;
        rd_data_q <= data_mem[{rp_d, drain_cnt_d}];
    end

    always_ff @(posedge clk) begin
        if (accept && (fill_cnt_q == '0)) tag_q[wp_q] <= wb_addr[31:LB];
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            logic [PW-1:0] offset;
            logic          live;
            // Live if inside the queued window [rp, rp+count) or being filled right now.
            assign offset      = PW'(gi) - rp_q;
            assign live        = ({1'b0, offset} < count_q) ||
                                 ((wp_q == PW'(gi)) && (fill_cnt_q != '0));
            assign hit_vec[gi] = live && (tag_q[gi] == chk_addr[31:LB]);
        end
    endgenerate

    assign unused_low_bits = ^{wb_addr[LB-1:0], chk_addr[LB-1:0]};

    assign chk_hit  = |hit_vec;
    assign wb_ready = wb_ready_q;
    assign wb_full  = (count_q == FULL_CNT);
    assign empty    = (count_q == '0) && (fill_cnt_q == '0);
    assign mem_req  = (state_q == SEND);
    assign mem_addr = {tag_q[rp_q], drain_cnt_q, 2'b00};
    assign mem_data = rd_data_q;

endmodule

// File: tb/tb_l2_write_buffer.sv
// Bench for l2_write_buffer: directed scenarios plus random traffic, all checked
// against a line/beat queue model of the buffer.
module tb_l2_write_buffer;
    localparam int DEPTH = 4;
    localparam int WORDS = 8;
    localparam int LB    = 5;

    logic        clk = 1'b0;
    logic        reset, write_l2, mem_ack;
    logic [31:0] wb_addr, wb_data, chk_addr;
    logic        wb_ready, wb_full, chk_hit, mem_req, empty;
    logic [31:0] mem_addr, mem_data;

    always #5 clk = ~clk;

    l2_write_buffer #(.DEPTH(DEPTH), .WORDS(WORDS)) dut (
        .clk(clk), .reset(reset), .write_l2(write_l2), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_ready(wb_ready), .wb_full(wb_full),
        .chk_addr(chk_addr), .chk_hit(chk_hit), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack), .empty(empty)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: completed lines waiting or draining, the line being filled,
    // and the flat sequence of beats L2 should see.
    int          occ = 0, prev_occ = 0, part_n = 0, drained = 0;
    bit          ready_exp = 0, last_acc = 0;
    logic [31:0] part_addr;
    logic [31:0] part_data [WORDS];
    logic [31:0] line_q [$];
    logic [31:0] exp_a_q [$];
    logic [31:0] exp_d_q [$];
    int          ack_mode = 0;
    logic [31:0] pool [4] = '{32'h0000_1000, 32'h0000_1020, 32'h0000_2000, 32'h0000_2040};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit same_line(input logic [31:0] a, input logic [31:0] b);
        return (a >> LB) == (b >> LB);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        bit h = 0;
        foreach (line_q[i]) if (same_line(line_q[i], a)) h = 1;
        if (part_n > 0 && same_line(part_addr, a)) h = 1;
        return h;
    endfunction

    task automatic step();
        bit          acc, dbeat, rst_in, fill_done, retire;
        logic [31:0] a_in, d_in;
        case (ack_mode)
            0: mem_ack = 1'b0;
            1: mem_ack = 1'b1;
            2: mem_ack = 1'($urandom_range(0, 1));
            3: mem_ack = ~mem_ack;
            default: ;
        endcase
        @(negedge clk);
        check("wb_full", wb_full, occ == DEPTH);
        check("empty", empty, (occ == 0) && (part_n == 0));
        check("wb_ready", wb_ready, ready_exp);
        check("mem_req", mem_req, (occ > 0) && (prev_occ > 0));
        check("chk_hit", chk_hit, model_hit(chk_addr));
        if (mem_req && exp_a_q.size() > 0) begin
            check("mem_addr", mem_addr, exp_a_q[0]);
            check("mem_data", mem_data, exp_d_q[0]);
        end
        acc    = write_l2 && (occ != DEPTH);
        dbeat  = mem_req && mem_ack && (exp_a_q.size() > 0);
        rst_in = reset;
        a_in   = wb_addr;
        d_in   = wb_data;
        @(posedge clk);
        if (rst_in) begin
            line_q.delete(); exp_a_q.delete(); exp_d_q.delete();
            occ = 0; prev_occ = 0; part_n = 0; drained = 0; ready_exp = 0;
            $display("reset applied at t=%0t", $time);
        end else begin
            prev_occ  = occ;
            fill_done = 0;
            retire    = 0;
            if (acc) begin
                if (part_n == 0) part_addr = a_in;
                part_data[part_n] = d_in;
                part_n++;
                if (part_n == WORDS) begin
                    for (int i = 0; i < WORDS; i++) begin
                        exp_a_q.push_back((part_addr & 32'hFFFF_FFE0) | 32'(i * 4));
                        exp_d_q.push_back(part_data[i]);
                    end
                    line_q.push_back(part_addr);
                    part_n    = 0;
                    fill_done = 1;
                end
            end
            if (dbeat) begin
                void'(exp_a_q.pop_front());
                void'(exp_d_q.pop_front());
                drained++;
                if (drained == WORDS) begin
                    $display("line retired: addr=%h", line_q[0] & 32'hFFFF_FFE0);
                    void'(line_q.pop_front());
                    drained = 0;
                    retire  = 1;
                end
            end
            ready_exp = fill_done;
            occ = occ + int'(fill_done) - int'(retire);
        end
        last_acc = acc && !rst_in;
        #1;
    endtask

    task automatic send_beats(input logic [31:0] a, input int first, input int last, input bit rnd);
        for (int b = first; b <= last; b++) begin
            int waited = 0;
            write_l2 = 1'b1;
            wb_addr  = (b == 0) ? a : $urandom;
            wb_data  = rnd ? $urandom : 32'(b);
            step();
            while (!last_acc && waited < 300) begin
                step();
                waited++;
            end
            check("fill_accept", last_acc, 1);
        end
        write_l2 = 1'b0;
    endtask

    task automatic drain_all();
        int n = 0;
        write_l2 = 1'b0;
        while (occ != 0 && n < 500) begin
            step();
            n++;
        end
        check("drain_done_occ", occ, 0);
        check("drain_empty", empty, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; write_l2 = 1'b0; mem_ack = 1'b0;
        wb_addr = '0; wb_data = '0; chk_addr = 32'h0000_2020;
        repeat (3) step();
        reset = 1'b0;
        check("rst_empty", empty, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_full", wb_full, 0);
        check("rst_ready", wb_ready, 0);

        // Single line, always acked
        ack_mode = 1;
        send_beats(32'h0000_1040, 0, WORDS - 1, 0);
        drain_all();

        // Fill to full, stall a fifth line, then release
        ack_mode = 0;
        for (int i = 0; i < DEPTH; i++) send_beats(32'h0000_4000 + 32'(i * 256), 0, WORDS - 1, 1);
        check("full_after4", wb_full, 1);
        write_l2 = 1'b1; wb_addr = 32'h0000_5000; wb_data = 32'hAAAA_5555;
        repeat (4) begin
            step();
            check("full_hold", wb_full, 1);
        end
        ack_mode = 1;
        send_beats(32'h0000_5000, 0, WORDS - 1, 1);
        drain_all();

        // Backpressure: ack every other cycle
        ack_mode = 3;
        send_beats(32'h0000_6000, 0, WORDS - 1, 1);
        send_beats(32'h0000_6100, 0, WORDS - 1, 1);
        drain_all();

        // Read-after-write hazard lookup
        chk_addr = 32'h0000_2014;
        ack_mode = 0;
        send_beats(32'h0000_2000, 0, WORDS - 1, 1);
        check("hit_buffered", chk_hit, 1);
        ack_mode = 1;
        drain_all();
        check("hit_drained", chk_hit, 0);
        chk_addr = 32'h0000_2020;
        ack_mode = 0;
        send_beats(32'h0000_2000, 0, WORDS - 1, 1);
        check("hit_other_line", chk_hit, 0);
        ack_mode = 1;
        drain_all();

        // Line completes and line retires on the same edge at three entries
        ack_mode = 4; mem_ack = 1'b0;
        send_beats(32'h0000_7000, 0, WORDS - 1, 1);
        send_beats(32'h0000_7100, 0, WORDS - 1, 1);
        send_beats(32'h0000_7200, 0, WORDS - 1, 1);
        send_beats(32'h0000_7300, 0, WORDS - 2, 1);
        mem_ack = 1'b1;
        repeat (WORDS - 1) step();
        write_l2 = 1'b1; wb_addr = $urandom; wb_data = $urandom;
        step();
        write_l2 = 1'b0; mem_ack = 1'b0;
        check("sim_full", wb_full, 0);
        check("sim_ready", wb_ready, 1);
        check("sim_mem_req", mem_req, 1);
        send_beats(32'h0000_7400, 0, WORDS - 1, 1);
        check("sim_occ_now_full", wb_full, 1);
        ack_mode = 1;
        drain_all();

        // Reset in the middle of a fill with two lines queued
        ack_mode = 0;
        send_beats(32'h0000_8000, 0, WORDS - 1, 1);
        send_beats(32'h0000_8100, 0, WORDS - 1, 1);
        send_beats(32'h0000_8200, 0, 3, 1);
        write_l2 = 1'b1; wb_data = $urandom; reset = 1'b1;
        step();
        reset = 1'b0; write_l2 = 1'b0;
        check("rst_mid_empty", empty, 1);
        check("rst_mid_mem_req", mem_req, 0);
        ack_mode = 1;
        send_beats(32'h0000_3000, 0, WORDS - 1, 0);
        drain_all();

        // Random traffic
        ack_mode = 2;
        for (int c = 0; c < 2000; c++) begin
            reset    = ($urandom_range(0, 599) == 0);
            write_l2 = ($urandom_range(0, 3) != 0);
            wb_addr  = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
            wb_data  = $urandom;
            chk_addr = ($urandom_range(0, 4) == 0) ? $urandom
                                                    : (pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 31)));
            step();
        end
        reset = 1'b0; write_l2 = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/l2_write_buffer.md
L2_WRITE_BUFFER -- requirements
Module: l2_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4: number of cache-line entries buffered; power of two, at least 2.
REQ-002 Parameter WORDS, default 8: 32-bit words per line (beats per burst); power of two.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 write_l2  in  1  upstream beat-valid from the L1 cache controller; one data word is offered per cycle while high.
REQ-006 wb_addr  in  32  line address of the victim line; sampled only on the first beat of a line.
REQ-007 wb_data  in  32  data word for the current beat.
REQ-008 wb_ready  out  1  one-cycle pulse when the last beat of a line has been accepted.
REQ-009 wb_full  out  1  high when all DEPTH entries are occupied; no beat is accepted while high.
REQ-010 chk_addr  in  32  line address of a pending L2 read (read_l2).
REQ-011 chk_hit  out  1  combinational; high when any occupied or partially filled entry matches chk_addr[31:5] (a line-address match).
REQ-012 mem_req  out  1  downstream beat-valid toward L2.
REQ-013 mem_addr  out  32  {line address[31:5], beat index, 2'b00}.
REQ-014 mem_data  out  32  data word for the current downstream beat.
REQ-015 mem_ack  in  1  L2 accepts the current beat when mem_req and mem_ack are both high.
REQ-016 empty  out  1  high when no entries are occupied and no fill is in progress.

Function
REQ-017 Storage: DEPTH entries of {line address, WORDS x 32 data}; circular write pointer (wp) and read pointer (rp); occupancy count 0..DEPTH.
REQ-018 Fill: a beat is accepted when write_l2=1 and wb_full=0; the beat counter (fill_cnt) selects the word and increments.
REQ-019 On the beat with fill_cnt=0, wb_addr is captured into entry[wp].
REQ-020 When the beat with fill_cnt=WORDS-1 is accepted: fill_cnt wraps to 0, wp advances modulo DEPTH, occupancy increments, and wb_ready pulses in the next cycle.
REQ-021 A beat offered while wb_full=1 is dropped without side effects; upstream holds write_l2 and retries.
REQ-022 If write_l2 drops mid-line, fill_cnt holds and the fill resumes at the same beat.
REQ-023 Drain FSM states: IDLE and SEND.
REQ-024 IDLE -> SEND when occupancy > 0.
REQ-025 In SEND, mem_req=1, mem_addr is taken from entry[rp] and beat counter drain_cnt, and mem_data = entry[rp].word[drain_cnt].
REQ-026 In SEND, on mem_ack: drain_cnt increments. On the final beat: drain_cnt wraps to 0, rp advances, occupancy decrements, and the FSM goes to IDLE when the new occupancy is 0, otherwise stays in SEND.
REQ-027 mem_req, mem_addr and mem_data stay stable while mem_req=1 and mem_ack=0.
REQ-028 Simultaneous line-complete (fill) and line-retire (drain) in the same cycle leaves occupancy unchanged; wb_full is computed from the updated occupancy.
REQ-029 A drain never reads the entry currently being filled; an entry becomes drainable only after its final beat.
REQ-030 Latency: the first mem_req occurs two cycles after the final fill beat when the buffer was empty.
REQ-031 chk_hit covers entries awaiting drain, the entry in SEND, and a partially filled entry whose first beat has been accepted.

Reset
REQ-032 While reset=1 at a clock edge, the following are cleared: wp, rp, occupancy, fill_cnt and drain_cnt to 0; the FSM to IDLE; wb_ready, mem_req and wb_full to 0; empty to 1.
REQ-033 Reset mid-fill or mid-drain discards all buffered data; entry data contents need not be cleared.
REQ-034 Outputs are valid in the first cycle after reset deasserts.

Verification
REQ-035 Single line: 8 beats, addr 0x0000_1040, data 0..7, mem_ack tied to 1 -> wb_ready pulses once; then 8 mem beats with addresses 0x1040, 0x1044, ..., 0x105C and data 0..7 in order; empty=1 afterwards.
REQ-036 Fill to full: 4 lines with mem_ack=0 -> wb_full=1 after the 4th wb_ready; a 5th-line beat is not accepted; one drained line (8 acks) -> wb_full=0 and the 5th line is accepted.
REQ-037 Backpressure: mem_ack toggling every other cycle -> mem_addr and mem_data stay stable while unacked; no beat is duplicated or skipped.
REQ-038 Hazard check: line 0x2000 buffered and chk_addr=0x2014 -> chk_hit=1; after the line is fully drained -> chk_hit=0; chk_addr=0x2020 -> chk_hit=0 throughout.
REQ-039 Simultaneous events: buffer at 3 entries, last fill beat and last drain ack in the same cycle -> occupancy stays 3 and wb_full stays 0.
REQ-040 Reset at fill beat 4 with 2 lines queued -> empty=1 and mem_req=0 the next cycle; a fresh line then drains correctly starting at beat 0.
